// File: rtl/rv_if_pkg.sv
// rv_if shared types and constants.
// FSM state enum, NOP encoding, PC increment.
package rv_if_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_STALL,
    S_FLUSH
  } t_if_state;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/rv_if_hold_buf.sv
// One-entry hold buffer plus Q101H instruction mux.
// Ports: clk, rst, capture, clear, valid, rdata -> instr, hold_vld.
module rv_if_hold_buf
  import rv_if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        clear,
  input  logic        valid,
  input  logic [31:0] rdata,
  output logic [31:0] instr,
  output logic        hold_vld
);

  logic [31:0] hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld <= 1'b0;
      hold_q   <= '0;
    end else if (clear) begin
      hold_vld <= 1'b0;
    end else if (capture) begin
      hold_vld <= 1'b1;
      hold_q   <= rdata;
    end
  end

  always_comb begin
    instr = NOP_INSTR;
    if (valid)
      instr = hold_vld ? hold_q : rdata;
  end

endmodule

// File: rtl/rv_if.sv
// Fetch stage Q100H->Q101H: PC, imem read, stall hold, redirects.
// Ports: clk, rst, ready/redirect in, imem rd/addr/rdata, Q101H out;
// fetch_cnt/stall_cnt only with RV_IF_PERF_CNT_EN defined.
module rv_if
  import rv_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready_Q101H,
  input  logic        redirect_en_Q102H,
  input  logic [31:0] redirect_pc_Q102H,
  output logic        imem_rd_en_Q100H,
  output logic [31:0] imem_addr_Q100H,
  input  logic [31:0] imem_rdata_Q101H,
  output logic [31:0] pc_Q101H,
  output logic [31:0] instruction_Q101H,
  output logic        valid_Q101H
`ifdef RV_IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  t_if_state   state;
  logic [31:0] pc_Q100H;
  logic        advance;
  logic        rd_en;
  logic        capture;
  logic        clear;
  logic        hold_vld;

  assign valid_Q101H = (state == S_RUN) |
                       (state == S_STALL);
  assign advance = ready_Q101H | ~valid_Q101H;
  assign rd_en   = ~rst & ~redirect_en_Q102H
                 & advance;

  assign imem_rd_en_Q100H = rd_en;
  assign imem_addr_Q100H  = pc_Q100H;

  // Freeze the live read word when decode stalls;
  // memory output is not guaranteed once rd_en drops.
  assign capture = ~redirect_en_Q102H
                 & (state == S_RUN)
                 & ~ready_Q101H;
  assign clear   = redirect_en_Q102H
                 | (hold_vld & ready_Q101H);

  rv_if_hold_buf u_hold (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .clear    (clear),
    .valid    (valid_Q101H),
    .rdata    (imem_rdata_Q101H),
    .instr    (instruction_Q101H),
    .hold_vld (hold_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_BOOT;
      pc_Q100H <= RESET_PC;
      pc_Q101H <= '0;
    end else if (redirect_en_Q102H) begin
      state    <= S_FLUSH;
      pc_Q100H <= redirect_pc_Q102H & ~32'd3;
    end else if (rd_en) begin
      state    <= S_RUN;
      pc_Q101H <= pc_Q100H;
      pc_Q100H <= pc_Q100H + PC_INC;
    end else if (capture) begin
      state    <= S_STALL;
    end
  end

`ifdef RV_IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (valid_Q101H & ready_Q101H & ~&fetch_cnt)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (valid_Q101H & ~ready_Q101H & ~&stall_cnt)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv_if.sv
// Self-checking bench for rv_if.
// Behavioural fetch model plus literal pins.
module tb_rv_if;
  import rv_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] rpc = '0;
  logic        rd_en;
  logic [31:0] addr;
  logic [31:0] rdata = '0;
  logic [31:0] pc101;
  logic [31:0] instr;
  logic        valid;
`ifdef RV_IF_PERF_CNT_EN
  logic [31:0] fcnt;
  logic [31:0] scnt;
`endif

  always #5 clk = ~clk;

  rv_if dut (
    .clk               (clk),
    .rst               (rst),
    .ready_Q101H       (ready),
    .redirect_en_Q102H (redir),
    .redirect_pc_Q102H (rpc),
    .imem_rd_en_Q100H  (rd_en),
    .imem_addr_Q100H   (addr),
    .imem_rdata_Q101H  (rdata),
    .pc_Q101H          (pc101),
    .instruction_Q101H (instr),
    .valid_Q101H       (valid)
`ifdef RV_IF_PERF_CNT_EN
    ,
    .fetch_cnt         (fcnt),
    .stall_cnt         (scnt)
`endif
  );

  function automatic logic [31:0] memf(
    input logic [31:0] a);
    return (a >> 2) ^ 32'h5A00_0000;
  endfunction

  // Sync memory; output is garbage when not read.
  always @(posedge clk)
    rdata <= rd_en ? memf(addr) : $urandom;

  int pass_n = 0;
  int tot_n  = 0;

  logic [31:0] m_fetch = '0;
  logic [31:0] m_pc    = '0;
  logic        m_valid = 1'b0;
  logic [31:0] m_fc    = '0;
  logic [31:0] m_sc    = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h want %h",
                  nm, act, exp);
  endtask

  task automatic cyc(input bit r, input bit rdy,
                     input bit rd,
                     input logic [31:0] tp,
                     input bit ck = 1'b1);
    logic exp_rd;
    @(negedge clk);
    rst = r; ready = rdy; redir = rd; rpc = tp;
    #1;
    exp_rd = !r && !rd && (rdy || !m_valid);
    if (ck) begin
      chk("valid", {31'd0, valid}, {31'd0, m_valid});
      if (m_valid) chk("pc", pc101, m_pc);
      chk("instr", instr,
          m_valid ? memf(m_pc) : NOP_INSTR);
      chk("rd_en", {31'd0, rd_en}, {31'd0, exp_rd});
      chk("addr", addr, m_fetch);
`ifdef RV_IF_PERF_CNT_EN
      chk("fetch_cnt", fcnt, m_fc);
      chk("stall_cnt", scnt, m_sc);
`endif
    end
    @(posedge clk);
    if (r) begin
      m_fetch = 32'h0;
      m_pc    = 32'h0;
      m_valid = 1'b0;
      m_fc    = 32'h0;
      m_sc    = 32'h0;
    end else begin
      if (m_valid && rdy && m_fc != 32'hFFFF_FFFF)
        m_fc = m_fc + 1;
      if (m_valid && !rdy && m_sc != 32'hFFFF_FFFF)
        m_sc = m_sc + 1;
      if (rd) begin
        m_fetch = tp & ~32'd3;
        m_valid = 1'b0;
      end else if (exp_rd) begin
        m_pc    = m_fetch;
        m_fetch = m_fetch + 32'd4;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic lit_pc(input string nm,
                        input logic [31:0] exp);
    #1;
    chk(nm, pc101, exp);
    chk({nm, "_v"}, {31'd0, valid}, 32'd1);
  endtask

  task automatic lit_inv(input string nm);
    #1;
    chk(nm, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    // reset and sequential fetch
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_pc", pc101, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    cyc(0, 1, 0, 0);
    lit_pc("seq0", 32'h0);
    chk("seq0_instr", instr, 32'h5A00_0000);
    cyc(0, 1, 0, 0); lit_pc("seq4", 32'h4);
    cyc(0, 1, 0, 0); lit_pc("seq8", 32'h8);
    // stall
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0); lit_pc("stall8", 32'h8);
      chk("stall_instr", instr, 32'h5A00_0002);
    end
    cyc(0, 1, 0, 0); lit_pc("after_stall", 32'hC);
    // redirect
    cyc(0, 1, 1, 32'h200); lit_inv("redir_bubble");
    cyc(0, 1, 0, 0); lit_pc("redir_tgt", 32'h200);
    // redirect during stall
    cyc(0, 1, 1, 32'h10);
    cyc(0, 1, 0, 0); lit_pc("pc10", 32'h10);
    cyc(0, 0, 0, 0); lit_pc("pc10_stall", 32'h10);
    cyc(0, 0, 1, 32'h200); lit_inv("stall_redir");
    cyc(0, 1, 0, 0); lit_pc("sr_tgt", 32'h200);
    cyc(0, 1, 0, 0); lit_pc("sr_next", 32'h204);
    // alignment and wrap
    cyc(0, 1, 1, 32'h203);
    cyc(0, 1, 0, 0); lit_pc("align", 32'h200);
    cyc(0, 1, 1, 32'hFFFF_FFFF);
    cyc(0, 1, 0, 0); lit_pc("top", 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0); lit_pc("wrap", 32'h0);
    // counters
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
`ifdef RV_IF_PERF_CNT_EN
    #1;
    chk("lit_fcnt", fcnt, 32'd10);
    chk("lit_scnt", scnt, 32'd3);
`endif
    cyc(1, 1, 0, 0);
`ifdef RV_IF_PERF_CNT_EN
    #1;
    chk("clr_fcnt", fcnt, 32'd0);
    chk("clr_scnt", scnt, 32'd0);
`endif
    // random
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(99) == 0,
          $urandom_range(9) < 7,
          $urandom_range(19) == 0,
          $urandom);
    cyc(0, 1, 0, 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
